// File: rtl/student_irq_fetch.sv
// Interrupt vector fetcher: reads IRQ_NO over TL-UL, optionally masks
// the line via MASK_CLR, then hands the vector to the consumer.
package tlul_pkg;
    localparam logic [2:0] PutFullData   = 3'h0;
    localparam logic [2:0] Get           = 3'h4;
    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module student_irq_fetch #(
    parameter int          N            = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [31:0] IRQ_NO_OFS   = 32'h10,
    parameter logic [31:0] MASK_CLR_OFS = 32'h08,
    parameter bit          AUTO_MASK    = 1'b1,
    localparam int         NW           = $clog2(N + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              irq_en_i,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i,
    output logic              vec_valid_o,
    output logic [NW-1:0]     vec_no_o,
    input  logic              vec_ready_i,
    output logic              err_o,
    output logic [7:0]        spurious_cnt_o,
    output logic              busy_o
);

    localparam logic [NW-1:0] N_V = NW'(N);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_RSP, MK_REQ, MK_RSP, DELIVER
    } state_e;

    state_e        state_q, state_d;
    logic [NW-1:0] no_q, no_d;
    logic [7:0]    spur_q, spur_d;
    logic          err_q, err_d;
    logic [NW-1:0] rsp_no;

    assign rsp_no = tl_i.d_data[NW-1:0];

    always_comb begin
        state_d = state_q;
        no_d    = no_q;
        spur_d  = spur_q;
        err_d   = 1'b0;

        tl_o           = '0;
        tl_o.a_size    = 2'd2;
        tl_o.a_mask    = 4'hF;
        tl_o.a_opcode  = tlul_pkg::Get;
        tl_o.a_address = BASE_ADDR + IRQ_NO_OFS;

        unique case (state_q)
            IDLE: begin
                if (irq_en_i && enable_i) state_d = RD_REQ;
            end
            RD_REQ: begin
                tl_o.a_valid = 1'b1;
                if (tl_i.a_ready) state_d = RD_RSP;
            end
            RD_RSP: begin
                tl_o.d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    if (tl_i.d_error) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (rsp_no >= N_V) begin
                        // Out-of-range numbers are spurious and never delivered
                        if (spur_q != 8'hFF) spur_d = spur_q + 8'd1;
                        state_d = IDLE;
                    end else begin
                        no_d    = rsp_no;
                        state_d = AUTO_MASK ? MK_REQ : DELIVER;
                    end
                end
            end
            MK_REQ: begin
                tl_o.a_valid   = 1'b1;
                tl_o.a_opcode  = tlul_pkg::PutFullData;
                tl_o.a_address = BASE_ADDR + MASK_CLR_OFS;
                tl_o.a_data    = 32'b1 << no_q;
                if (tl_i.a_ready) state_d = MK_RSP;
            end
            MK_RSP: begin
                tl_o.d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    err_d   = tl_i.d_error;
                    state_d = tl_i.d_error ? IDLE : DELIVER;
                end
            end
            DELIVER: begin
                if (vec_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            no_q    <= '0;
            spur_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            no_q    <= no_d;
            spur_q  <= spur_d;
            err_q   <= err_d;
        end
    end

    assign vec_valid_o    = (state_q == DELIVER);
    assign vec_no_o       = no_q;
    assign err_o          = err_q;
    assign spurious_cnt_o = spur_q;
    assign busy_o         = (state_q != IDLE);

endmodule
